// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_STEPS = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    SIGN = ST_SIGN,
    DONE = ST_DONE
  } md_state_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_DIV   = 2'b01,
    MD_MULTU = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step
// on the shared {accHi, accLo} accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] addend;

  always_comb begin
    addend  = accLo[0] ? operand : {WIDTH{1'b0}};
    sum     = {1'b0, accHi} + {1'b0, addend};
    shifted = {accHi, accLo[WIDTH-1]};
    nextHi  = sum[WIDTH:1];
    nextLo  = {sum[0], accLo[WIDTH-1:1]};
    if (isDiv) begin
      // Remainder stays below the divisor, so the W-bit subtraction cannot wrap.
      if (shifted >= {1'b0, operand}) begin
        nextHi = shifted[WIDTH-1:0] - operand;
        nextLo = {accLo[WIDTH-2:0], 1'b1};
      end else begin
        nextHi = shifted[WIDTH-1:0];
        nextLo = {accLo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/DIV sequencer with architectural HI/LO registers.
// MULDIV_UNSIGNED_EN enables MULTU/DIVU; otherwise those ops raise op_err.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes allowed
// RUN   | one multiply/divide step per clock, WIDTH steps
// SIGN  | sign fix-up, HI/LO written
// DONE  | done pulse, result visible on HI/LO
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             op_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t        state;
  md_op_t           opSel;
  logic [CW-1:0]    stepCnt;
  logic [WIDTH-1:0] accHi, accLo, operandB;
  logic [WIDTH-1:0] nextHi, nextLo;
  logic             isDiv, negRes, negRem;
  logic             opOk, opIsDiv, opSigned, divByZero, signA, signB;
  logic [WIDTH-1:0] magA, magB;
  logic [2*WIDTH-1:0] prod, prodFix;
  logic [WIDTH-1:0] quoFix, remFix;

  assign opSel    = md_op_t'(op);
  assign opIsDiv  = (opSel == MD_DIV) || (opSel == MD_DIVU);
  assign opSigned = (opSel == MD_MULT) || (opSel == MD_DIV);

`ifdef MULDIV_UNSIGNED_EN
  assign opOk = 1'b1;
`else
  assign opOk = opSigned;
`endif

  assign divByZero = opIsDiv && (opb == '0);
  assign signA     = opSigned & opa[WIDTH-1];
  assign signB     = opSigned & opb[WIDTH-1];
  assign magA      = signA ? -opa : opa;
  assign magB      = signB ? -opb : opb;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .isDiv   (isDiv),
    .accHi   (accHi),
    .accLo   (accLo),
    .operand (operandB),
    .nextHi  (nextHi),
    .nextLo  (nextLo)
  );

  always_comb begin
    prod    = {accHi, accLo};
    prodFix = negRes ? -prod : prod;
    quoFix  = negRes ? -accLo : accLo;
    remFix  = negRem ? -accHi : accHi;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      stepCnt  <= '0;
      accHi    <= '0;
      accLo    <= '0;
      operandB <= '0;
      isDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      op_err   <= 1'b0;
    end else begin
      op_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (opOk) begin
              // Multiply keeps the multiplier in accLo; divide keeps the dividend there.
              div_zero <= divByZero;
              isDiv    <= opIsDiv;
              negRes   <= signA ^ signB;
              negRem   <= signA;
              stepCnt  <= CW'(WIDTH - 1);
              accHi    <= '0;
              accLo    <= opIsDiv ? magA : magB;
              operandB <= opIsDiv ? magB : magA;
              state    <= divByZero ? DONE : RUN;
            end else begin
              op_err <= 1'b1;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          accHi <= nextHi;
          accLo <= nextLo;
          if (stepCnt == '0) state <= SIGN;
          else               stepCnt <= stepCnt - CW'(1);
        end
        SIGN: begin
          if (isDiv) begin
            hi <= remFix;
            lo <= quoFix;
          end else begin
            {hi, lo} <= prodFix;
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a transaction-level arithmetic model.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset_n, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] opa, opb, wdata;
  logic        busy, done, div_zero, op_err;
  logic [31:0] hi, lo;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .opa(opa), .opb(opb), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .op_err(op_err),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int nCmp = 0;
  int nBad = 0;
  int cycNo = 0;

  // Model: architectural HI/LO, sticky div_zero, and edges left until idle.
  logic [31:0] mHi, mLo, pHi, pLo;
  logic        mDz, mDone, mOpErr;
  int          mLeft;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = sa * sb;
      2'b10: p = {32'b0, a} * {32'b0, b};
      2'b01: begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
      default: p = {a % b, a / b};
    endcase
    return p;
  endfunction

  task automatic modelEdge(input logic st, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic hwe, input logic lwe,
                           input logic [31:0] wd);
    logic [63:0] r;
    logic ok;
    mDone  = 1'b0;
    mOpErr = 1'b0;
    if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 1) begin
        mDone = 1'b1;
        mHi   = pHi;
        mLo   = pLo;
      end
    end else if (st) begin
`ifdef MULDIV_UNSIGNED_EN
      ok = 1'b1;
`else
      ok = !o[1];
`endif
      if (!ok) mOpErr = 1'b1;
      else if (o[0] && b == 32'd0) begin
        mDz = 1'b1; mLeft = 1; mDone = 1'b1;
      end else begin
        mDz = 1'b0;
        r = refResult(o, a, b);
        pHi = r[63:32];
        pLo = r[31:0];
        mLeft = 34;
      end
    end else begin
      if (hwe) mHi = wd;
      if (lwe) mLo = wd;
    end
  endtask

  task automatic compareAll();
    check("busy", busy, mLeft > 0);
    check("done", done, mDone);
    check("div_zero", div_zero, mDz);
    check("op_err", op_err, mOpErr);
    check("hi", hi, mHi);
    check("lo", lo, mLo);
  endtask

  task automatic cyc(input logic st, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic hwe, input logic lwe,
                     input logic [31:0] wd);
    start = st; op = o; opa = a; opb = b; hi_we = hwe; lo_we = lwe; wdata = wd;
    @(posedge clock);
    modelEdge(st, o, a, b, hwe, lwe, wd);
    @(negedge clock);
    cycNo++;
    compareAll();
  endtask

  // lat = edges from the start edge until done is seen high, -1 if never.
  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int c0;
    lat = -1;
    cyc(1'b1, o, a, b, 1'b0, 1'b0, 32'd0);
    c0 = cycNo;
    for (int i = 0; i < 40; i++) begin
      if (lat < 0 && done) lat = cycNo - c0;
      if (!busy && mLeft == 0) break;
      cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [1:0] ro;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    mHi = '0; mLo = '0; pHi = '0; pLo = '0; mDz = 1'b0; mDone = 1'b0; mOpErr = 1'b0; mLeft = 0;
    repeat (3) @(negedge clock);
    compareAll();
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset_n = 1'b1;

    runOp(2'b00, 32'd7, 32'hFFFF_FFFD, lat);
    check("mult_latency", lat, 33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    runOp(2'b01, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    runOp(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 32'h1234);
    runOp(2'b01, 32'd5, 32'd0, lat);
    check("dz_latency", lat, 0);
    check("dz_flag", div_zero, 1'b1);
    check("dz_hi", hi, 32'h1234);
    check("dz_lo", lo, 32'h1234);
    runOp(2'b00, 32'd2, 32'd3, lat);
    check("dz_cleared", div_zero, 1'b0);
    check("dz_next_lo", lo, 32'd6);

    cyc(1'b1, 2'b00, 32'd100, 32'd200, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 40 && mLeft > 0; i++)
      cyc(i == 5, 2'b01, 32'd9, 32'd9, i == 5 || i == 20, i == 20, 32'hDEAD_BEEF);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'd20000);

    cyc(1'b1, 2'b00, 32'd12345, 32'd678, 1'b0, 1'b0, 32'd0);
    repeat (10) cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    reset_n = 1'b0;
    #1;
    mHi = '0; mLo = '0; mDz = 1'b0; mDone = 1'b0; mOpErr = 1'b0; mLeft = 0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    compareAll();
    runOp(2'b00, 32'd3, 32'd11, lat);
    check("after_rst_lo", lo, 32'd33);
    check("after_rst_latency", lat, 33);

`ifdef MULDIV_UNSIGNED_EN
    runOp(2'b10, 32'hFFFF_FFFF, 32'd2, lat);
    check("multu_hi", hi, 32'd1);
    check("multu_lo", lo, 32'hFFFF_FFFE);
`else
    cyc(1'b1, 2'b10, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd0);
    check("multu_op_err", op_err, 1'b1);
    check("multu_busy", busy, 1'b0);
    cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("multu_op_err_pulse", op_err, 1'b0);
    check("multu_lo_kept", lo, 32'd33);
`endif

    for (int t = 0; t < 150; t++) begin
      ro = 2'($urandom_range(0, 3));
      cyc(1'b1, ro, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      for (int i = 0; i < 40 && mLeft > 0; i++)
        cyc($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2))
        cyc(1'b0, 2'b00, 32'd0, 32'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
